// File: rtl/idu_exu_csr.sv
// RV32I combinational decode/execute slice with a small machine-mode CSR file.
// The CSR file (mcycle, minstret, mscratch) is the only sequential state.
module idu_exu_csr (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic        req_valid,
  output logic        resp_valid,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] lsu_rdata,
  output logic [5:0]  inst_type,
  output logic        rf_wen,
  output logic [31:0] rf_wdata,
  output logic [31:0] lsu_addr,
  output logic [31:0] lsu_wdata,
  output logic        is_pc_jump,
  output logic [31:0] pc_jump,
  input  logic        is_instret,
  input  logic        is_ebreak,
  output logic        ebreak_hit
);

  typedef enum logic [5:0] {
    T_REG    = 6'b000000, T_IMM   = 6'b000001, T_LUI  = 6'b000010,
    T_AUIPC  = 6'b000011, T_JAL   = 6'b000100, T_JALR = 6'b000101,
    T_BRANCH = 6'b000110, T_CSR   = 6'b000111, T_CSRI = 6'b001000,
    T_EBREAK = 6'b001001, T_UNDEF = 6'b001111,
    T_LB     = 6'b010000, T_LH    = 6'b010001, T_LW   = 6'b010010,
    T_LBU    = 6'b010100, T_LHU   = 6'b010101,
    T_SB     = 6'b011000, T_SH    = 6'b011001, T_SW   = 6'b011010
  } inst_type_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  inst_type_e  itype;
  logic        is_load, is_store;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  alu_op_e     alu_op;
  logic [31:0] op_b, alu_res;
  logic [4:0]  shamt;
  logic        br_taken;

  logic [63:0] mcycle, minstret;
  logic [31:0] mscratch;
  logic [11:0] csr_addr;
  logic [31:0] csr_old, csr_src, csr_new;
  logic        csr_wr;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign resp_valid = req_valid;
  assign inst_type  = itype;
  assign ebreak_hit = (itype == T_EBREAK);
  assign is_load    = (itype[5:3] == 3'b010);
  assign is_store   = (itype[5:3] == 3'b011);

  always_comb begin
    itype = T_UNDEF;
    case (opcode)
      7'b0110011:
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          itype = T_REG;
      7'b0010011:
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) itype = T_IMM;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000 || funct7 == 7'b0100000) itype = T_IMM;
        end else begin
          itype = T_IMM;
        end
      7'b0110111: itype = T_LUI;
      7'b0010111: itype = T_AUIPC;
      7'b1101111: itype = T_JAL;
      7'b1100111: if (funct3 == 3'b000) itype = T_JALR;
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) itype = T_BRANCH;
      7'b0000011:
        case (funct3)
          3'b000:  itype = T_LB;
          3'b001:  itype = T_LH;
          3'b010:  itype = T_LW;
          3'b100:  itype = T_LBU;
          3'b101:  itype = T_LHU;
          default: itype = T_UNDEF;
        endcase
      7'b0100011:
        case (funct3)
          3'b000:  itype = T_SB;
          3'b001:  itype = T_SH;
          3'b010:  itype = T_SW;
          default: itype = T_UNDEF;
        endcase
      7'b1110011:
        if (funct3 == 3'b000) begin
          if (inst == 32'h0010_0073) itype = T_EBREAK;
        end else if (funct3 == 3'b100) begin
          itype = T_UNDEF;
        end else begin
          itype = funct3[2] ? T_CSRI : T_CSR;
        end
      default: itype = T_UNDEF;
    endcase
  end

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm = imm_i;
    if (is_store)                                imm = imm_s;
    else if (itype == T_BRANCH)                  imm = imm_b;
    else if (itype == T_LUI || itype == T_AUIPC) imm = imm_u;
    else if (itype == T_JAL)                     imm = imm_j;
  end

  // inst[30] picks SUB only in R-form; it picks SRA in both forms.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (itype == T_REG && inst[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = inst[30] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  assign op_b  = (itype == T_REG) ? rdata2 : imm;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = rdata1 + op_b;
      ALU_SUB:  alu_res = rdata1 - op_b;
      ALU_SLL:  alu_res = rdata1 << shamt;
      ALU_SLT:  alu_res = {31'b0, $signed(rdata1) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, rdata1 < op_b};
      ALU_XOR:  alu_res = rdata1 ^ op_b;
      ALU_SRL:  alu_res = rdata1 >> shamt;
      ALU_SRA:  alu_res = 32'($signed(rdata1) >>> shamt);
      ALU_OR:   alu_res = rdata1 | op_b;
      default:  alu_res = rdata1 & op_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rdata1 == rdata2);
      3'b001:  br_taken = (rdata1 != rdata2);
      3'b100:  br_taken = ($signed(rdata1) <  $signed(rdata2));
      3'b101:  br_taken = ($signed(rdata1) >= $signed(rdata2));
      3'b110:  br_taken = (rdata1 <  rdata2);
      3'b111:  br_taken = (rdata1 >= rdata2);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    is_pc_jump = 1'b0;
    pc_jump    = pc + imm;
    case (itype)
      T_JAL:    is_pc_jump = 1'b1;
      T_JALR: begin
        is_pc_jump = 1'b1;
        pc_jump    = (rdata1 + imm) & ~32'd1;
      end
      T_BRANCH: is_pc_jump = br_taken;
      default:  is_pc_jump = 1'b0;
    endcase
  end

  assign lsu_addr  = rdata1 + imm;
  assign lsu_wdata = rdata2;

  assign csr_addr = inst[31:20];
  assign csr_src  = (itype == T_CSRI) ? {27'b0, inst[19:15]} : rdata1;

  always_comb begin
    csr_old = '0;
    case (csr_addr)
      CSR_MSCRATCH:  csr_old = mscratch;
      CSR_MCYCLE:    csr_old = mcycle[31:0];
      CSR_MCYCLEH:   csr_old = mcycle[63:32];
      CSR_MINSTRET:  csr_old = minstret[31:0];
      CSR_MINSTRETH: csr_old = minstret[63:32];
      CSR_MVENDORID: csr_old = 32'h7973_7978;
      CSR_MARCHID:   csr_old = 32'h0000_0001;
      default:       csr_old = '0;
    endcase
  end

  always_comb begin
    csr_new = csr_old;
    case (funct3[1:0])
      2'b01:   csr_new = csr_src;
      2'b10:   csr_new = csr_old | csr_src;
      2'b11:   csr_new = csr_old & ~csr_src;
      default: csr_new = csr_old;
    endcase
  end

  assign csr_wr = req_valid && (itype == T_CSR || itype == T_CSRI) &&
                  (funct3[1:0] == 2'b01 || csr_src != '0);

  always_comb begin
    rf_wdata = '0;
    case (itype)
      T_REG, T_IMM:  rf_wdata = alu_res;
      T_LUI:         rf_wdata = imm;
      T_AUIPC:       rf_wdata = pc + imm;
      T_JAL, T_JALR: rf_wdata = pc + 32'd4;
      T_CSR, T_CSRI: rf_wdata = csr_old;
      default:       rf_wdata = is_load ? lsu_rdata : '0;
    endcase
  end

  assign rf_wen = req_valid && (rd != 5'd0) && !is_store &&
                  itype != T_BRANCH && itype != T_EBREAK && itype != T_UNDEF;

  // Software writes are placed after the increments so they win for that edge;
  // the untouched half keeps its old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcycle   <= '0;
      minstret <= '0;
      mscratch <= '0;
    end else begin
      if (!is_ebreak) mcycle   <= mcycle + 64'd1;
      if (is_instret) minstret <= minstret + 64'd1;
      if (csr_wr) begin
        case (csr_addr)
          CSR_MSCRATCH:  mscratch <= csr_new;
          CSR_MCYCLE:    mcycle   <= {mcycle[63:32], csr_new};
          CSR_MCYCLEH:   mcycle   <= {csr_new, mcycle[31:0]};
          CSR_MINSTRET:  minstret <= {minstret[63:32], csr_new};
          CSR_MINSTRETH: minstret <= {csr_new, minstret[31:0]};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idu_exu_csr.sv
// Directed bench for idu_exu_csr: decode/ALU/branch/LSU vectors, CSR ops and counters.
module tb_idu_exu_csr;

  logic        clock, reset;
  logic [31:0] inst, pc, rdata1, rdata2, lsu_rdata;
  logic        req_valid, is_instret, is_ebreak;
  logic        resp_valid, rf_wen, is_pc_jump, ebreak_hit;
  logic [4:0]  rd, rs1, rs2;
  logic [5:0]  inst_type;
  logic [31:0] rf_wdata, lsu_addr, lsu_wdata, pc_jump;

  int unsigned total  = 0;
  int unsigned passed = 0;

  idu_exu_csr dut (
    .clock(clock), .reset(reset), .inst(inst), .pc(pc),
    .req_valid(req_valid), .resp_valid(resp_valid),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2), .lsu_rdata(lsu_rdata),
    .inst_type(inst_type), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .is_pc_jump(is_pc_jump), .pc_jump(pc_jump),
    .is_instret(is_instret), .is_ebreak(is_ebreak), .ebreak_hit(ebreak_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // csrrs x5,<a>,x0 with req_valid low: a pure read, never a write.
  task automatic csr_read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    inst = {a, 5'd0, 3'b010, 5'd5, 7'h73};
    rdata1 = '0;
    req_valid = 1'b0;
    #1;
    check(tag, rf_wdata, exp);
  endtask

  task automatic step_edge();
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; inst = 32'h0000_0013; pc = '0; req_valid = 1'b0;
    rdata1 = '0; rdata2 = '0; lsu_rdata = '0; is_instret = 1'b0; is_ebreak = 1'b0;
    #2;
    csr_read_check("rst_mcycle", 12'hB00, 32'h0);
    csr_read_check("rst_minstret", 12'hB02, 32'h0);
    csr_read_check("rst_mscratch", 12'h340, 32'h0);

    // addi x1,x0,-5
    inst = 32'hFFB0_0093; req_valid = 1'b1; #1;
    check("addi_type", 32'(inst_type), 32'h01);
    check("addi_wen", 32'(rf_wen), 32'h1);
    check("addi_rd", 32'(rd), 32'h1);
    check("addi_wdata", rf_wdata, 32'hFFFF_FFFB);
    check("resp_valid", 32'(resp_valid), 32'h1);
    req_valid = 1'b0; #1;
    check("addi_nowen_invalid", 32'(rf_wen), 32'h0);
    inst = 32'h0050_0013; req_valid = 1'b1; #1;
    check("addi_x0_nowen", 32'(rf_wen), 32'h0);

    // sub / sltu / sra / srai / srli
    rdata1 = 32'd3; rdata2 = 32'd5;
    inst = 32'h4020_81B3; #1; check("sub", rf_wdata, 32'hFFFF_FFFE);
    inst = 32'h0020_B1B3; #1; check("sltu", rf_wdata, 32'h1);
    rdata1 = 32'h8000_0000; rdata2 = 32'd4;
    inst = 32'h4020_D1B3; #1; check("sra", rf_wdata, 32'hF800_0000);
    inst = 32'h4040_D193; #1; check("srai", rf_wdata, 32'hF800_0000);
    inst = 32'h0040_D193; #1; check("srli", rf_wdata, 32'h0800_0000);

    // beq x1,x2,-8 at pc 0x100
    pc = 32'h100; rdata1 = 32'h55; rdata2 = 32'h55; inst = 32'hFE20_8CE3; #1;
    check("beq_taken", 32'(is_pc_jump), 32'h1);
    check("beq_target", pc_jump, 32'h0000_00F8);
    check("beq_nowen", 32'(rf_wen), 32'h0);
    rdata2 = 32'h56; #1;
    check("beq_not_taken", 32'(is_pc_jump), 32'h0);

    // jalr x1,4(x2)
    rdata1 = 32'h203; inst = 32'h0041_00E7; #1;
    check("jalr_target", pc_jump, 32'h206);
    check("jalr_link", rf_wdata, 32'h104);
    check("jalr_jump", 32'(is_pc_jump), 32'h1);

    // sw x2,8(x1)
    rdata1 = 32'h1000; rdata2 = 32'hCAFE_F00D; inst = 32'h0020_A423; #1;
    check("sw_addr", lsu_addr, 32'h1008);
    check("sw_wdata", lsu_wdata, 32'hCAFE_F00D);
    check("sw_nowen", 32'(rf_wen), 32'h0);
    check("sw_type", 32'(inst_type), 32'h1A);

    // lw x1,0(x2), lui, ebreak, undefined
    lsu_rdata = 32'h1234_5678; inst = 32'h0001_2083; #1;
    check("lw_type", 32'(inst_type), 32'h12);
    check("lw_wdata", rf_wdata, 32'h1234_5678);
    inst = 32'h1234_50B7; #1; check("lui", rf_wdata, 32'h1234_5000);
    inst = 32'h0010_0073; #1;
    check("ebreak_type", 32'(inst_type), 32'h09);
    check("ebreak_hit", 32'(ebreak_hit), 32'h1);
    check("ebreak_nowen", 32'(rf_wen), 32'h0);
    inst = 32'hFFFF_FFFF; #1;
    check("undef_type", 32'(inst_type), 32'h0F);
    check("undef_nowen", 32'(rf_wen), 32'h0);
    req_valid = 1'b0; inst = 32'h0000_0013;

    // Counters: 10 edges out of reset with 3 instret pulses
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      is_instret = (i < 3);
      @(posedge clock);
      #1;
    end
    is_instret = 1'b0;
    csr_read_check("mcycle_10", 12'hB00, 32'd10);
    csr_read_check("minstret_3", 12'hB02, 32'd3);
    is_ebreak = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    csr_read_check("mcycle_frozen", 12'hB00, 32'd10);
    csr_read_check("minstret_hold", 12'hB02, 32'd3);

    // mscratch read/write/set/clear
    inst = 32'h3403_12F3; rdata1 = 32'hDEAD; req_valid = 1'b1; #1;
    check("csrrw_old", rf_wdata, 32'h0);
    check("csrrw_wen", 32'(rf_wen), 32'h1);
    step_edge();
    inst = 32'h3400_22F3; rdata1 = 32'h0; req_valid = 1'b1; #1;
    check("csrrs_read", rf_wdata, 32'hDEAD);
    step_edge();
    inst = 32'h3401_E2F3; req_valid = 1'b1; #1;
    check("csrrsi_type", 32'(inst_type), 32'h08);
    check("csrrsi_old", rf_wdata, 32'hDEAD);
    step_edge();
    csr_read_check("mscratch_set", 12'h340, 32'hDEAF);
    inst = 32'h3403_32F3; rdata1 = 32'hF; req_valid = 1'b1;
    step_edge();
    csr_read_check("mscratch_clr", 12'h340, 32'hDEA0);
    inst = 32'hF113_12F3; rdata1 = 32'h1234; req_valid = 1'b1;
    step_edge();
    csr_read_check("mvendorid_ro", 12'hF11, 32'h7973_7978);
    csr_read_check("marchid", 12'hF12, 32'h1);
    csr_read_check("unimpl_zero", 12'h7C0, 32'h0);

    // 64-bit wrap of mcycle
    inst = 32'hB003_12F3; rdata1 = 32'hFFFF_FFFF; req_valid = 1'b1;
    step_edge();
    inst = 32'hB803_12F3; rdata1 = 32'hFFFF_FFFF; req_valid = 1'b1;
    step_edge();
    csr_read_check("mcycle_lo_ones", 12'hB00, 32'hFFFF_FFFF);
    csr_read_check("mcycle_hi_ones", 12'hB80, 32'hFFFF_FFFF);
    is_ebreak = 1'b0;
    @(posedge clock);
    #1;
    csr_read_check("mcycle_lo_wrap", 12'hB00, 32'h0);
    csr_read_check("mcycle_hi_wrap", 12'hB80, 32'h0);

    // Same-edge software write beats the increment
    inst = 32'hB003_12F3; rdata1 = 32'h100; req_valid = 1'b1;
    step_edge();
    csr_read_check("mcycle_override", 12'hB00, 32'h100);
    csr_read_check("mcycleh_kept", 12'hB80, 32'h0);
    is_instret = 1'b1;
    inst = 32'hB023_12F3; rdata1 = 32'd5; req_valid = 1'b1;
    step_edge();
    is_instret = 1'b0;
    csr_read_check("minstret_override", 12'hB02, 32'd5);

    // Asynchronous reset mid-run
    #2;
    reset = 1'b0;
    csr_read_check("async_rst_mcycle", 12'hB00, 32'h0);
    csr_read_check("async_rst_minstret", 12'hB02, 32'h0);
    csr_read_check("async_rst_mscratch", 12'h340, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
